// File: rtl/hdc_pkg.sv
// rtl/hdc_pkg.sv - shared defaults, FSM states and item-memory generator for the HDC encoder
package hdc_pkg;
   localparam int N_DEFAULT     = 10000;
   localparam int SYM_W_DEFAULT = 5;
   localparam int SPACE_SYM     = 26;
   localparam int HV_MAX_W      = 32 * ((N_DEFAULT + 31) / 32);

   typedef enum logic [2:0] {IDLE, FILL, ACCUM, THRESH, OUT} enc_state_t;

   // Cyclic left rotate of the low n bits of vec by k
   function automatic logic [HV_MAX_W-1:0] rho(input logic [HV_MAX_W-1:0] vec, input int k,
                                                input int n);
      logic [HV_MAX_W-1:0] r;
      r = '0;
      for (int i = 0; i < n; i++) r[(i + k) % n] = vec[i];
      return r;
   endfunction

   // xorshift32 seeded with seed^sym, one 32-bit word per step, LSB-first; zero state is remapped
   function automatic logic [HV_MAX_W-1:0] gen_item_hv(input logic [31:0] sym,
                                                       input logic [31:0] seed, input int n);
      logic [HV_MAX_W-1:0] hv;
      logic [31:0]         x;
      hv = '0;
      x  = seed ^ sym;
      if (x == 32'h0) x = 32'h9E37_79B9;
      for (int w = 0; w < (n + 31) / 32; w++) begin
         x = x ^ (x << 13);
         x = x ^ (x >> 17);
         x = x ^ (x << 5);
         hv[w*32 +: 32] = x;
      end
      return hv;
   endfunction
endpackage

// File: rtl/hdc_item_memory.sv
// rtl/hdc_item_memory.sv - combinational symbol to hypervector lookup from an elaboration-time table
module hdc_item_memory
   import hdc_pkg::*;
#(
   parameter int          N           = 64,
   parameter int          SYM_W       = 5,
   parameter int          NUM_SYMBOLS = 27,
   parameter logic [31:0] SEED        = 32'h1
) (
   input  logic [SYM_W-1:0] sym_i,
   output logic [N-1:0]     hv_o
);
   logic [N-1:0] rom [NUM_SYMBOLS];

   for (genvar s = 0; s < NUM_SYMBOLS; s++) begin : g_rom
      localparam logic [HV_MAX_W-1:0] FULL_HV = gen_item_hv(32'(s), SEED, N);
      assign rom[s] = FULL_HV[N-1:0];
   end

   always_comb begin
      hv_o = rom[SPACE_SYM];
      if (int'(sym_i) < NUM_SYMBOLS) hv_o = rom[sym_i];
   end
endmodule

// File: rtl/hdc_text_encoder.sv
// rtl/hdc_text_encoder.sv - permutation n-gram text encoder with per-bit majority bundling
// Optional: MAJ_TIEBREAK_EN resolves majority ties from the rotated first n-gram.
module hdc_text_encoder
   import hdc_pkg::*;
#(
   parameter int          N           = N_DEFAULT,
   parameter int          NGRAM       = 3,
   parameter int          SYM_W       = SYM_W_DEFAULT,
   parameter int          NUM_SYMBOLS = 27,
   parameter int          CNT_W       = 16,
   parameter logic [31:0] SEED        = 32'h1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             char_valid,
   output logic             char_ready,
   input  logic [SYM_W-1:0] char_data,
   input  logic             char_last,
   output logic             vec_valid,
   input  logic             vec_ready,
   output logic [N-1:0]     text_vector,
   output logic [CNT_W-1:0] ngram_count,
   output logic             overflow
);
   localparam int               FILL_W  = $clog2(NGRAM + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   enc_state_t                        state_q, state_d;
   logic [NGRAM-1:0][SYM_W-1:0]       hist_q, hist_d;
   logic [FILL_W-1:0]                 fill_q;
   logic [CNT_W-1:0]                  count_q;
   logic [CNT_W-1:0]                  cnt_q [N];
   logic                              ovf_q;
   logic [N-1:0]                      tv_q;
   logic [N-1:0]                      hv [NGRAM];
   logic [N-1:0]                      rot [NGRAM];
   logic [N-1:0]                      ngram, maj;
   logic [SYM_W-1:0]                  sym;
   logic                              accept, completes, add_en, drop, clear;
`ifdef MAJ_TIEBREAK_EN
   logic [N-1:0]                      tb_q;
`endif

   assign char_ready  = (state_q == IDLE) || (state_q == FILL) || (state_q == ACCUM);
   assign accept      = char_valid && char_ready;
   assign sym         = (int'(char_data) >= NUM_SYMBOLS) ? SYM_W'(SPACE_SYM) : char_data;
   // The window of the n-gram that the incoming symbol completes is the shifted history
   assign hist_d      = {sym, hist_q[NGRAM-1:1]};
   assign completes   = (int'(fill_q) == NGRAM - 1);
   assign add_en      = accept && completes && (count_q != CNT_MAX);
   assign drop        = accept && completes && (count_q == CNT_MAX);
   assign clear       = (state_q == OUT) && vec_ready;
   assign text_vector = tv_q;
   assign ngram_count = count_q;
   assign overflow    = ovf_q;

   for (genvar j = 0; j < NGRAM; j++) begin : g_slot
      localparam int K = NGRAM - 1 - j;
      hdc_item_memory #(.N(N), .SYM_W(SYM_W), .NUM_SYMBOLS(NUM_SYMBOLS), .SEED(SEED)) u_im (
         .sym_i (hist_d[j]),
         .hv_o  (hv[j])
      );
      if (K == 0) begin : g_norot
         assign rot[j] = hv[j];
      end else begin : g_rot
         assign rot[j] = {hv[j][N-1-K:0], hv[j][N-1:N-K]};
      end
   end

   always_comb begin
      ngram = '0;
      for (int j = 0; j < NGRAM; j++) ngram = ngram ^ rot[j];
   end

   always_comb begin
      maj = '0;
      for (int i = 0; i < N; i++) begin
         maj[i] = {cnt_q[i], 1'b0} > {1'b0, count_q};
`ifdef MAJ_TIEBREAK_EN
         if ({cnt_q[i], 1'b0} == {1'b0, count_q}) maj[i] = tb_q[i];
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      vec_valid = 1'b0;
      case (state_q)
         IDLE, FILL: if (accept) begin
            if (char_last)                         state_d = THRESH;
            else if (int'(fill_q) + 1 >= NGRAM - 1) state_d = ACCUM;
            else                                   state_d = FILL;
         end
         ACCUM:  if (accept && char_last) state_d = THRESH;
         THRESH: state_d = OUT;
         OUT: begin
            vec_valid = 1'b1;
            if (vec_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         hist_q  <= '0;
         fill_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         tv_q    <= '0;
         for (int i = 0; i < N; i++) cnt_q[i] <= '0;
`ifdef MAJ_TIEBREAK_EN
         tb_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         if (clear) begin
            hist_q  <= '0;
            fill_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < N; i++) cnt_q[i] <= '0;
`ifdef MAJ_TIEBREAK_EN
            tb_q    <= '0;
`endif
         end else begin
            if (accept) begin
               hist_q <= hist_d;
               if (!completes) fill_q <= fill_q + FILL_W'(1);
            end
            if (add_en) begin
               count_q <= count_q + CNT_W'(1);
               for (int i = 0; i < N; i++) cnt_q[i] <= cnt_q[i] + CNT_W'(ngram[i]);
`ifdef MAJ_TIEBREAK_EN
               if (count_q == '0) tb_q <= {ngram[N-2:0], ngram[N-1]};
`endif
            end
            if (drop) ovf_q <= 1'b1;
            if (state_q == THRESH) tv_q <= maj;
         end
      end
   end
endmodule
